vga_frame_reader: RTL and testbench

- Read side of the 256×256×3-bit video memory that the MiniAlu `VGA` instruction writes.
- Generates 640×480 @ 60 Hz VGA timing from the 50 MHz system clock, using a pixel enable every second clock.
- Fetches one RGB pixel per pixel period through the memory's read port and drives the board's VGA pins.
- Also provides `oVBlank` and `oFrameStart` status signals, so software can time its writes to avoid tearing.

---
 rtl/vga_frame_reader.sv | 143 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// vga_frame_reader
// Read side of the 256x256x3-bit video memory. Generates 640x480@60 Hz VGA
// timing from a 50 MHz clock (one pixel every second clock), fetches one RGB
// pixel per pixel period through the memory read port, and drives the VGA
// pins together with vertical-blank and frame-start status.
//
// Memory read port timing: oReadAddress is held for both clocks of a pixel
// period; iReadData is expected one clock after an address is presented and
// is captured on the pixel's second clock, so a 1-clock memory latency is
// absorbed without stalling. There is no arbitration with writers: whatever
// the memory returns is shown.
//
// Pipeline: counters -> stage A (window flag, address, raw sync/blank/start)
// -> stage B (colour gating and output registers). Every output for a counter
// value (H,V) appears exactly two clocks after the counters take that value,
// so sync, blank, frame-start and colour stay mutually aligned.

module vga_frame_reader #(
  parameter int WIN_COL = 192,
  parameter int WIN_ROW = 112
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  iReadData,
  output logic [15:0] oReadAddress,
  output logic        oVGA_RED,
  output logic        oVGA_GREEN,
  output logic        oVGA_BLUE,
  output logic        oVGA_HSYNC,
  output logic        oVGA_VSYNC,
  output logic        oVBlank,
  output logic        oFrameStart
);

  // Line: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  // Frame: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
  localparam logic [9:0] V_LAST       = 10'd524;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;
  // Image window bounds (256x256), end values are exclusive.
  localparam logic [9:0] WIN_COL_FIRST = 10'(WIN_COL);
  localparam logic [9:0] WIN_COL_END   = 10'(WIN_COL + 256);
  localparam logic [9:0] WIN_ROW_FIRST = 10'(WIN_ROW);
  localparam logic [9:0] WIN_ROW_END   = 10'(WIN_ROW + 256);

  logic       phase;
  logic       tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;

  // Stage A next values and registers.
  logic        win_next;
  logic [15:0] addr_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        vblank_next;
  logic        fs_next;
  logic        win_a;
  logic        hsync_a;
  logic        vsync_a;
  logic        vblank_a;
  logic        fs_a;

  // A pixel period is two clocks; the counters move on the second one.
  assign tick   = phase;
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Pixel-enable phase: toggles every clock.
  always_ff @(posedge Clock) begin
    if (!Reset) phase <= 1'b0;
    else        phase <= ~phase;
  end

  // Horizontal counter 0..799, advances once per pixel period.
  always_ff @(posedge Clock) begin
    if (!Reset)    h_cnt <= 10'd0;
    else if (tick) h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
  end

  // Vertical counter 0..524, advances when the horizontal counter wraps.
  always_ff @(posedge Clock) begin
    if (!Reset)              v_cnt <= 10'd0;
    else if (tick && h_wrap) v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
  end

  // Stage A decode: window test, window-relative address, raw sync/blank/start.
  // Offsets wrap to 8 bits; inside the window they are always 0..255.
  always_comb begin
    win_next    = (h_cnt >= WIN_COL_FIRST) && (h_cnt < WIN_COL_END) &&
                  (v_cnt >= WIN_ROW_FIRST) && (v_cnt < WIN_ROW_END);
    addr_next   = 16'h0000;
    if (win_next)
      addr_next = {8'(v_cnt - WIN_ROW_FIRST), 8'(h_cnt - WIN_COL_FIRST)};
    hsync_next  = !((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST));
    vsync_next  = !((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST));
    vblank_next = (v_cnt >= V_VISIBLE);
    fs_next     = (h_cnt == 10'd0) && (v_cnt == 10'd0) && !phase;
  end

  // Stage A registers: the memory address leaves the block from here.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      win_a        <= 1'b0;
      oReadAddress <= 16'h0000;
      hsync_a      <= 1'b1;
      vsync_a      <= 1'b1;
      vblank_a     <= 1'b0;
      fs_a         <= 1'b0;
    end else begin
      win_a        <= win_next;
      oReadAddress <= addr_next;
      hsync_a      <= hsync_next;
      vsync_a      <= vsync_next;
      vblank_a     <= vblank_next;
      fs_a         <= fs_next;
    end
  end

  // Stage B output registers: colour gated by the window, status copied.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      {oVGA_RED, oVGA_GREEN, oVGA_BLUE} <= 3'b000;
      oVGA_HSYNC  <= 1'b1;
      oVGA_VSYNC  <= 1'b1;
      oVBlank     <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      {oVGA_RED, oVGA_GREEN, oVGA_BLUE} <= win_a ? iReadData : 3'b000;
      oVGA_HSYNC  <= hsync_a;
      oVGA_VSYNC  <= vsync_a;
      oVBlank     <= vblank_a;
      oFrameStart <= fs_a;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader
// Drives vga_frame_reader with a 1-clock-latency video memory and random
// reset points, and compares every output on every clock against a reference
// model that derives the expected picture from the clock index since reset.

module tb_vga_frame_reader;

  localparam int WIN_COL = 192;
  localparam int WIN_ROW = 112;
  localparam int FRAME_CLKS = 840000;

  // ---------------- clock / reset ----------------
  logic        Clock = 1'b0;
  logic        Reset;
  logic [2:0]  iReadData;
  logic [15:0] oReadAddress;
  logic        oVGA_RED, oVGA_GREEN, oVGA_BLUE;
  logic        oVGA_HSYNC, oVGA_VSYNC, oVBlank, oFrameStart;

  always #10 Clock = ~Clock;

  vga_frame_reader #(.WIN_COL(WIN_COL), .WIN_ROW(WIN_ROW)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iReadData    (iReadData),
    .oReadAddress (oReadAddress),
    .oVGA_RED     (oVGA_RED),
    .oVGA_GREEN   (oVGA_GREEN),
    .oVGA_BLUE    (oVGA_BLUE),
    .oVGA_HSYNC   (oVGA_HSYNC),
    .oVGA_VSYNC   (oVGA_VSYNC),
    .oVBlank      (oVBlank),
    .oFrameStart  (oFrameStart)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_bad    = 0;
  bit give_up  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      if (n_bad >= 50) give_up = 1'b1;
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0] rand_mem [65536];

  // Counter position at clock index k after the last reset edge.
  function automatic void cnt_at(input int k, output int h, output int v, output int ph);
    int p;
    p  = k / 2;
    h  = p % 800;
    v  = (p / 800) % 525;
    ph = k % 2;
  endfunction

  function automatic bit in_win(input int h, input int v);
    return (h >= WIN_COL) && (h < WIN_COL + 256) && (v >= WIN_ROW) && (v < WIN_ROW + 256);
  endfunction

  // Memory content: rows whose offset r has (r+1)%3==0 hold random data,
  // the others return addr[2:0].
  function automatic logic [2:0] mem_fn(input logic [15:0] a);
    int r;
    r = int'(a[15:8]);
    if ((r + 1) % 3 == 0) return rand_mem[a];
    return a[2:0];
  endfunction

  // Address on the port during clock index n.
  function automatic logic [15:0] exp_addr(input int n);
    int h, v, ph;
    if (n == 0) return 16'h0000;
    cnt_at(n - 1, h, v, ph);
    if (!in_win(h, v)) return 16'h0000;
    return {8'(v - WIN_ROW), 8'(h - WIN_COL)};
  endfunction

  // Lines with V%3==2 are driven with constant white by the memory model.
  function automatic bit white_line(input int v);
    return (v % 3) == 2;
  endfunction

  // Expected {addr, rgb, hsync, vsync, vblank, framestart} at clock index n.
  function automatic logic [22:0] exp_out(input int n);
    int h, v, ph;
    logic [2:0] rd, rgb;
    logic hs, vs, vb, fs;
    if (n < 2) return {exp_addr(n), 3'b000, 1'b1, 1'b1, 1'b0, 1'b0};
    cnt_at(n - 2, h, v, ph);
    hs  = !(h >= 656 && h <= 751);
    vs  = !(v >= 490 && v <= 491);
    vb  = (v >= 480);
    fs  = (h == 0 && v == 0 && ph == 0);
    rd  = white_line(v) ? 3'b111 : mem_fn(exp_addr(n - 2));
    rgb = in_win(h, v) ? rd : 3'b000;
    return {exp_addr(n), rgb, hs, vs, vb, fs};
  endfunction

  // ---------------- driver / monitor ----------------
  int         n = 0;            // clock index of the interval being observed
  logic [15:0] prev_addr = 16'h0;
  bit         prev_white = 1'b0;
  bit         hold_white = 1'b0;

  bit line_full = 1'b0, frame_full = 1'b0;
  int line_v, white_cnt, first_white, hs_low, first_hs;
  int vs_low, vb_high, frames_done = 0;

  task automatic eval_line();
    if (line_v >= WIN_ROW && line_v < WIN_ROW + 256 && white_line(line_v)) begin
      check_eq("line_white_clocks", 32'(white_cnt), 32'd512);
      check_eq("line_white_start", 32'(first_white), 32'd384);
    end else if (line_v < WIN_ROW || line_v >= WIN_ROW + 256) begin
      check_eq("line_no_white", 32'(white_cnt), 32'd0);
    end
    check_eq("hsync_low_clocks", 32'(hs_low), 32'd192);
    check_eq("hsync_fall_pos", 32'(first_hs), 32'd1312);
  endtask

  task automatic eval_frame();
    check_eq("vsync_low_clocks", 32'(vs_low), 32'd3200);
    check_eq("vblank_clocks", 32'(vb_high), 32'd72000);
    frames_done++;
  endtask

  task automatic named_checks();
    int h, v, ph;
    logic [2:0] rgb;
    rgb = {oVGA_RED, oVGA_GREEN, oVGA_BLUE};
    if (n == 0)
      check_eq("reset_state",
               32'({oReadAddress, rgb, oVGA_HSYNC, oVGA_VSYNC, oVBlank, oFrameStart}),
               32'({16'h0000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0}));
    if (n == 2)          check_eq("fs_after_release", 32'(oFrameStart), 32'd1);
    if (n == FRAME_CLKS + 2) check_eq("fs_next_frame", 32'(oFrameStart), 32'd1);
    if (n >= 1) begin
      cnt_at(n - 1, h, v, ph);
      if (ph == 1) begin
        if (h == 192 && v == 112) check_eq("addr_192_112", 32'(oReadAddress), 32'h0000);
        if (h == 197 && v == 112) check_eq("addr_197_112", 32'(oReadAddress), 32'h0005);
        if (h == 447 && v == 367) check_eq("addr_447_367", 32'(oReadAddress), 32'hffff);
        if (h == 191 && v == 112) check_eq("addr_191_112", 32'(oReadAddress), 32'h0000);
        if (h == 192 && v == 368) check_eq("addr_192_368", 32'(oReadAddress), 32'h0000);
      end
    end
    if (n >= 2) begin
      cnt_at(n - 2, h, v, ph);
      if (ph == 1) begin
        if (h == 192 && v == 112) check_eq("rgb_192_112", 32'(rgb), 32'h0);
        if (h == 197 && v == 112) check_eq("rgb_197_112", 32'(rgb), 32'h5);
        if (h == 447 && v == 367) check_eq("rgb_447_367", 32'(rgb), 32'h7);
        if (h == 191 && v == 112) check_eq("rgb_191_112", 32'(rgb), 32'h0);
        if (h == 192 && v == 368) check_eq("rgb_192_368", 32'(rgb), 32'h0);
      end
    end
  endtask

  task automatic track_stats();
    int h, v, ph, pos;
    if (n < 2) begin
      line_full  = 1'b0;
      frame_full = 1'b0;
      return;
    end
    cnt_at(n - 2, h, v, ph);
    if (h == 0 && ph == 0) begin
      if (line_full) eval_line();
      line_full = 1'b1; line_v = v;
      white_cnt = 0; first_white = -1; hs_low = 0; first_hs = -1;
    end
    if (h == 0 && v == 0 && ph == 0) begin
      if (frame_full) eval_frame();
      frame_full = 1'b1; vs_low = 0; vb_high = 0;
    end
    pos = 2 * h + ph;
    if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} == 3'b111) begin
      white_cnt++;
      if (first_white < 0) first_white = pos;
    end
    if (!oVGA_HSYNC) begin
      hs_low++;
      if (first_hs < 0) first_hs = pos;
    end
    if (!oVGA_VSYNC) vs_low++;
    if (oVBlank) vb_high++;
  endtask

  // One clock: check outputs mid-cycle, answer the memory read, set Reset
  // for the coming edge.
  task automatic cycle(input logic rst_n_next);
    int h, v, ph;
    @(negedge Clock);
    check_eq("outputs",
             32'({oReadAddress, oVGA_RED, oVGA_GREEN, oVGA_BLUE,
                  oVGA_HSYNC, oVGA_VSYNC, oVBlank, oFrameStart}),
             32'(exp_out(n)));
    named_checks();
    track_stats();
    // Memory: data for the address seen one clock ago.
    if (hold_white)      iReadData = 3'b111;
    else if (prev_white) iReadData = 3'b111;
    else                 iReadData = mem_fn(prev_addr);
    prev_addr = oReadAddress;
    cnt_at(n, h, v, ph);
    prev_white = white_line(v);
    Reset = rst_n_next;
    n = rst_n_next ? n + 1 : 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h, v, ph, tgt, k;
    bit hit;
    for (int i = 0; i < 65536; i++) rand_mem[i] = 3'($urandom);
    Reset      = 1'b0;
    iReadData  = 3'b111;
    hold_white = 1'b1;

    // Five reset edges with white on the data bus.
    repeat (4) cycle(1'b0);
    hold_white = 1'b0;

    // Run briefly, then a short random reset pulse.
    k = $urandom_range(50, 3000);
    repeat (k) cycle(1'b1);
    k = $urandom_range(1, 3);
    repeat (k) cycle(1'b0);

    // Run to HSYNC-low on output line 300, then reset there.
    tgt = $urandom_range(660, 740);
    hit = 1'b0;
    for (int g = 0; g < 500000 && !give_up; g++) begin
      if (n >= 2) begin
        cnt_at(n - 2, h, v, ph);
        if (v == 300 && h == tgt && ph == 0) begin
          hit = 1'b1;
          break;
        end
      end
      cycle(1'b1);
    end
    check_eq("line300_reached", 32'(hit), 32'd1);
    k = $urandom_range(1, 4);
    repeat (k) cycle(1'b0);

    // One full frame and the next frame start after the restart.
    while (n < FRAME_CLKS + 10 && !give_up) cycle(1'b1);
    check_eq("full_frames", 32'(frames_done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
